ni_rx_vc_arbiter: RTL

//  Parametrised single-clock receive side of the neuron network interface. Steers router flits

---
 rtl/ni_rx_vc_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ni_rx_vc_arbiter.sv
// Receive side of the neuron NI: per-VC flit FIFOs, credit return, wormhole-locked
// round-robin packet arbitration and a registered valid/ready port to the spike decoder.

module ni_rx_vc_fifo #(
  parameter int W  = 38,
  parameter int AW = 3
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  logic [W-1:0] mem [2**AW];
  logic [AW:0]  wp, rp;

  always_ff @(posedge clk) begin
    if (clr) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module ni_rx_vc_arbiter #(
  parameter int VIRTUAL_CHANNEL = 4,
  parameter int PAYLOAD_WIDTH   = 32,
  parameter int FIFO_AW         = 3,
  parameter int TYPE_WIDTH      = 3,
  localparam int FLIT_WIDTH     = 2 + VIRTUAL_CHANNEL + PAYLOAD_WIDTH
) (
  input  logic                       neuron_clk,
  input  logic                       neuron_rst,
  input  logic                       start,
  input  logic                       flit_in_wr,
  input  logic [FLIT_WIDTH-1:0]      flit_in,
  output logic [VIRTUAL_CHANNEL-1:0] credit_out,
  output logic [FLIT_WIDTH-1:0]      flit_to_decoder,
  output logic                       flit_valid,
  input  logic                       decoder_ready,
  output logic [TYPE_WIDTH-1:0]      packet_type,
  output logic                       activate_decoder,
  output logic                       stall_decoder,
  output logic                       overflow_err,
  output logic                       proto_err
);
  localparam int VW = $clog2(VIRTUAL_CHANNEL);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;
  localparam logic [1:0] HDR_HEAD = 2'b10;
  localparam logic [1:0] HDR_TAIL = 2'b01;

  logic                                        clr;
  logic [VIRTUAL_CHANNEL-1:0]                  vc_field, push_vec, pop_vec, empty, full;
  logic [VIRTUAL_CHANNEL-1:0][FLIT_WIDTH-1:0]  fifo_dout;
  logic                                        vc_onehot, wr_err, can_pop, idle_found;
  logic [VW-1:0]                               rr_ptr, lock_vc, idle_sel, sel, cand;
  logic [0:0]                                  state;
  logic [FLIT_WIDTH-1:0]                       head;
  logic [1:0]                                  head_hdr;

  assign clr       = !neuron_rst || start;
  assign vc_field  = flit_in[FLIT_WIDTH-3 -: VIRTUAL_CHANNEL];
  assign vc_onehot = (vc_field != '0) && ((vc_field & (vc_field - 1'b1)) == '0);
  // Fullness is the pre-pop view, so a write to a full FIFO drops even if it pops now.
  assign wr_err    = flit_in_wr && (!vc_onehot || (|(vc_field & full)));

  for (genvar v = 0; v < VIRTUAL_CHANNEL; v++) begin : g_vc
    assign push_vec[v] = flit_in_wr && vc_onehot && vc_field[v] && !full[v] && !clr;
    ni_rx_vc_fifo #(.W(FLIT_WIDTH), .AW(FIFO_AW)) u_fifo (
      .clk  (neuron_clk),
      .clr  (clr),
      .push (push_vec[v]),
      .pop  (pop_vec[v]),
      .din  (flit_in),
      .dout (fifo_dout[v]),
      .empty(empty[v]),
      .full (full[v])
    );
  end

  // Round-robin search starts one past the last granted VC and ends on it.
  always_comb begin
    idle_sel   = '0;
    idle_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= VIRTUAL_CHANNEL; k++) begin
      cand = VW'((int'(rr_ptr) + k) % VIRTUAL_CHANNEL);
      if (!idle_found && !empty[cand]) begin
        idle_found = 1'b1;
        idle_sel   = cand;
      end
    end
  end

  assign sel        = (state == LOCKED) ? lock_vc : idle_sel;
  assign can_pop    = (!flit_valid || decoder_ready) && !empty[sel] && !clr;
  assign pop_vec    = can_pop ? ({{(VIRTUAL_CHANNEL-1){1'b0}}, 1'b1} << sel) : '0;
  assign credit_out = pop_vec;
  assign head       = fifo_dout[sel];
  assign head_hdr   = head[FLIT_WIDTH-1 -: 2];

  always_ff @(posedge neuron_clk) begin
    if (clr) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      lock_vc         <= '0;
      flit_to_decoder <= '0;
      flit_valid      <= 1'b0;
      overflow_err    <= 1'b0;
      proto_err       <= 1'b0;
    end else begin
      if (wr_err) overflow_err <= 1'b1;
      if (can_pop) begin
        flit_to_decoder <= head;
        flit_valid      <= 1'b1;
        if (state == IDLE) begin
          if (head_hdr == HDR_HEAD) begin
            state   <= LOCKED;
            lock_vc <= sel;
          end else begin
            rr_ptr <= sel;
            if (!head_hdr[1]) proto_err <= 1'b1;
          end
        end else begin
          if (head_hdr == HDR_TAIL) begin
            state  <= IDLE;
            rr_ptr <= sel;
          end else if (head_hdr[1]) begin
            proto_err <= 1'b1;
          end
        end
      end else if (decoder_ready) begin
        flit_valid <= 1'b0;
      end
    end
  end

  assign packet_type      = flit_to_decoder[PAYLOAD_WIDTH-1 -: TYPE_WIDTH];
  assign activate_decoder = flit_valid && flit_to_decoder[FLIT_WIDTH-1];
  assign stall_decoder    = (state == LOCKED) && empty[lock_vc] && !flit_valid;
endmodule
